mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Sequencing front-end for the 16-entry register-file `memory` block. It drives that block's `address`, `load_mem`, `memory_out_en` and `din` pins, and receives its `dout`. It assembles a byte-serial boot stream into 32-bit words and writes them to consecutive addresses. It also serves single-word CPU read requests over a ready/valid handshake, so no other logic touches the memory pins directly.

## Interface
- `data_size`, default 32: memory word width; must be 32, since 4 bytes make one word.
- `load_words`, default 16: number of words written per load session (1..16), always starting at address 0.

- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `load_start`, input, 1: request to begin a load session. Accepted only in IDLE.
- `byte_in`, input, 8: boot stream byte.
- `byte_valid`, input, 1: `byte_in` is valid.
- `byte_ready`, output, 1: controller accepts a byte. A transfer occurs when `byte_valid & byte_ready`.
- `load_done`, output, 1: sticky flag indicating the last load session completed.
- `rd_req`, input, 1: CPU read request.
- `rd_addr`, input, 4: read address, sampled on acceptance.
- `rd_ready`, output, 1: read request can be accepted this cycle.
- `rd_valid`, output, 1: one-cycle pulse indicating `rd_data` is valid.
- `rd_data`, output, 32: registered read result.
- `busy`, output, 1: high in every state except IDLE.
- `mem_address`, output, 4: connects to memory `address`.
- `mem_load`, output, 1: connects to memory `load_mem`.
- `mem_out_en`, output, 1: connects to memory `memory_out_en`.
- `mem_din`, output, 32: connects to memory `din`.
- `mem_dout`, input, 32: connects to memory `dout`.

## Operation
- States: IDLE, LOAD_BYTE, LOAD_WRITE, READ.
- IDLE:
  - `load_start` takes priority over `rd_req`.
  - On `load_start`: clear `load_done`, `wr_ptr`=0, `byte_cnt`=0, go to LOAD_BYTE.
  - Otherwise `rd_ready`=1. On `rd_req`: latch `rd_addr`, go to READ.
- LOAD_BYTE:
  - `byte_ready`=1.
  - Each accepted byte is placed at `word[8*byte_cnt +: 8]` (little-endian: first byte lands in bits 7:0), and `byte_cnt` increments.
  - On the 4th byte, go to LOAD_WRITE.
  - Cycles without `byte_valid` are stalls, with no timeout.
- LOAD_WRITE (exactly one cycle):
  - Drive `mem_load`=1, `mem_address`=`wr_ptr`, `mem_din`=`word`.
  - If `wr_ptr`==`load_words`-1: set `load_done`, go to IDLE.
  - Else: `wr_ptr`+1, `byte_cnt`=0, go to LOAD_BYTE.
- READ (exactly one cycle):
  - Drive `mem_out_en`=1, `mem_address`=latched address.
  - Capture `mem_dout` into `rd_data` at the clock edge, then go to IDLE.
  - `rd_valid`=1 for the following cycle only.
- `mem_address` is `wr_ptr` in LOAD states, the latched read address in READ, and 0 in IDLE.
- `mem_load` and `mem_out_en` are never high together, and are low outside LOAD_WRITE and READ respectively.
- Ignored inputs:
  - `load_start` outside IDLE.
  - `rd_req` while `rd_ready`=0. The request is not queued; the requester holds `rd_req`.
  - `byte_valid` outside LOAD_BYTE.
- Reads of never-written addresses are legal and return whatever memory holds (0 after reset).
- `wr_ptr` is 4 bits. With `load_words`=16 the last write is at address 15 and the pointer is not advanced past it, so there is no wrap.

## Timing
- Reset (async assert, sync release) sets:
  - state IDLE;
  - `byte_ready`, `rd_valid`, `load_done`, `busy`, `mem_load`, `mem_out_en` to 0;
  - `rd_data`, `mem_din`, `mem_address` to 0;
  - `rd_ready` to 1 after release.
- Reset mid-load abandons the session. The partial word is discarded and `load_done` stays 0. Words already written remain in memory unless memory is also reset, which it is, since both share `reset`.
- Read latency: request accepted at edge N, READ during cycle N+1, `rd_valid`/`rd_data` in cycle N+2. `rd_ready` is high again in N+2, so back-to-back throughput is one read per 2 cycles.
- Load throughput: 5 cycles per word with bytes streaming every cycle. Minimum 80 cycles for 16 words.
- `rd_data` holds its value until the next read completes.
- `busy` is a registered decode of the state.

## Test plan
- Reset with `load_start`=1, `rd_req`=1 held -> all outputs 0 and `rd_ready`=0 during reset; after release, a load session starts (priority rule) and `rd_ready` drops.
- Load 64 bytes 0x00..0x3F back-to-back -> 16 `mem_load` pulses at addresses 0..15; address 0 gets `mem_din`=0x03020100, address 15 gets 0x3F3E3D3C; `load_done`=1 after the last one.
- Same load with `byte_valid` toggled every other cycle -> identical memory contents; `byte_ready` is high only in LOAD_BYTE; no pulse is missing or extra.
- After the load, `rd_req` with `rd_addr`=5 at edge N -> `mem_out_en`=1, `mem_address`=5 in N+1; `rd_valid`=1 with `rd_data`=0x17161514 in N+2 only.
- `rd_req` asserted mid-load, and `load_start` asserted again mid-load -> both ignored, `rd_ready`=0, session completes unchanged; the read is accepted in the first IDLE cycle.
- Assert `reset` after 10 bytes -> state IDLE and `load_done`=0. A new 64-byte load then completes normally.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl -- boot-stream word loader and single-word read sequencer for the 16-entry memory.
// Rev 1.0
`default_nettype none

module mem_ctrl #(
  parameter int data_size  = 32,
  parameter int load_words = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_start,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 load_done,
  input  logic                 rd_req,
  input  logic [3:0]           rd_addr,
  output logic                 rd_ready,
  output logic                 rd_valid,
  output logic [data_size-1:0] rd_data,
  output logic                 busy,
  output logic [3:0]           mem_address,
  output logic                 mem_load,
  output logic                 mem_out_en,
  output logic [data_size-1:0] mem_din,
  input  logic [data_size-1:0] mem_dout
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_LOAD_BYTE  = 2'd1,
    S_LOAD_WRITE = 2'd2,
    S_READ       = 2'd3
  } state_t;

  localparam logic [3:0] c_last_ptr = 4'(load_words - 1);

  state_t               r_state;
  logic [3:0]           r_wr_ptr;
  logic [1:0]           r_byte_cnt;
  logic [data_size-1:0] r_word;
  logic                 r_byte_ready;
  logic                 r_load_done;
  logic                 r_rd_ready;
  logic                 r_rd_valid;
  logic [data_size-1:0] r_rd_data;
  logic                 r_busy;
  logic [3:0]           r_mem_address;
  logic                 r_mem_load;
  logic                 r_mem_out_en;
  logic [data_size-1:0] r_mem_din;
  logic [data_size-1:0] w_word_next;

  // Little-endian assembly: the first byte of each word lands in bits 7:0.
  always_comb begin
    w_word_next = r_word;
    w_word_next[{r_byte_cnt, 3'b000} +: 8] = byte_in;
  end

  // All outputs are registered, so each transition also loads the outputs of the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= 4'd0;
      r_byte_cnt    <= 2'd0;
      r_word        <= '0;
      r_byte_ready  <= 1'b0;
      r_load_done   <= 1'b0;
      r_rd_ready    <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_rd_data     <= '0;
      r_busy        <= 1'b0;
      r_mem_address <= 4'd0;
      r_mem_load    <= 1'b0;
      r_mem_out_en  <= 1'b0;
      r_mem_din     <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_load_done   <= 1'b0;
            r_wr_ptr      <= 4'd0;
            r_byte_cnt    <= 2'd0;
            r_state       <= S_LOAD_BYTE;
            r_byte_ready  <= 1'b1;
            r_rd_ready    <= 1'b0;
            r_busy        <= 1'b1;
            r_mem_address <= 4'd0;
          end else if (rd_req && r_rd_ready) begin
            r_state       <= S_READ;
            r_rd_ready    <= 1'b0;
            r_busy        <= 1'b1;
            r_mem_out_en  <= 1'b1;
            r_mem_address <= rd_addr;
          end else begin
            r_rd_ready <= 1'b1;
          end
        end
        S_LOAD_BYTE: begin
          if (byte_valid) begin
            r_word     <= w_word_next;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state      <= S_LOAD_WRITE;
              r_byte_ready <= 1'b0;
              r_mem_load   <= 1'b1;
              r_mem_din    <= w_word_next;
            end
          end
        end
        S_LOAD_WRITE: begin
          r_mem_load <= 1'b0;
          if (r_wr_ptr == c_last_ptr) begin
            r_load_done   <= 1'b1;
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_rd_ready    <= 1'b1;
            r_mem_address <= 4'd0;
          end else begin
            r_wr_ptr      <= r_wr_ptr + 4'd1;
            r_byte_cnt    <= 2'd0;
            r_state       <= S_LOAD_BYTE;
            r_byte_ready  <= 1'b1;
            r_mem_address <= r_wr_ptr + 4'd1;
          end
        end
        S_READ: begin
          r_mem_out_en  <= 1'b0;
          r_rd_data     <= mem_dout;
          r_rd_valid    <= 1'b1;
          r_state       <= S_IDLE;
          r_busy        <= 1'b0;
          r_rd_ready    <= 1'b1;
          r_mem_address <= 4'd0;
        end
        default: begin
          r_state       <= S_IDLE;
          r_byte_ready  <= 1'b0;
          r_busy        <= 1'b0;
          r_mem_load    <= 1'b0;
          r_mem_out_en  <= 1'b0;
          r_mem_address <= 4'd0;
        end
      endcase
    end
  end

  assign byte_ready  = r_byte_ready;
  assign load_done   = r_load_done;
  assign rd_ready    = r_rd_ready;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign busy        = r_busy;
  assign mem_address = r_mem_address;
  assign mem_load    = r_mem_load;
  assign mem_out_en  = r_mem_out_en;
  assign mem_din     = r_mem_din;

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl -- directed self-checking bench for mem_ctrl with a behavioural 16x32 memory.
// Rev 1.0
`default_nettype none

module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        load_done;
  logic        rd_req = 1'b0;
  logic [3:0]  rd_addr = 4'd0;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        busy;
  logic [3:0]  mem_address;
  logic        mem_load;
  logic        mem_out_en;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:15];
  logic [3:0]  log_addr [0:63];
  logic [31:0] log_data [0:63];
  int          wr_cnt = 0;
  int          viol = 0;

  mem_ctrl #(.data_size(32), .load_words(16)) dut (
    .clk(clk), .reset(reset), .load_start(load_start),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .load_done(load_done), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .mem_address(mem_address), .mem_load(mem_load),
    .mem_out_en(mem_out_en), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  assign mem_dout = mem_out_en ? mem[mem_address] : 32'd0;

  // Memory model plus write log and protocol-violation counter, all sampled mid-cycle.
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    end else begin
      if (mem_load) begin
        mem[mem_address] = mem_din;
        if (wr_cnt < 64) begin
          log_addr[wr_cnt] = mem_address;
          log_data[wr_cnt] = mem_din;
        end
        wr_cnt = wr_cnt + 1;
      end
      if (byte_ready && (mem_load || mem_out_en || !busy)) viol = viol + 1;
      if (mem_load && mem_out_en) viol = viol + 1;
    end
  end

  function automatic logic [31:0] exp_word(input int i);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(4 * i);
    b1 = 8'(4 * i + 1);
    b2 = 8'(4 * i + 2);
    b3 = 8'(4 * i + 3);
    return {b3, b2, b1, b0};
  endfunction

  // Starts a session and streams bytes 0..nbytes-1; inject raises rd_req/load_start mid-stream.
  task automatic run_load(input int stall, input int inject, input int nbytes);
    int idx, cyc;
    logic tog;
    idx = 0; cyc = 0; tog = 1'b0;
    wr_cnt = 0;
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    while (idx < nbytes && cyc < 2000) begin
      if (inject != 0 && idx == 8) begin
        load_start = 1'b1; rd_req = 1'b1; rd_addr = 4'd2;
      end
      if (inject != 0 && idx == 20) load_start = 1'b0;
      if (inject != 0 && rd_ready) viol = viol + 1;
      if (stall != 0) tog = ~tog;
      byte_in    = idx[7:0];
      byte_valid = (stall != 0) ? tog : 1'b1;
      @(negedge clk);
      cyc++;
      if (byte_valid && byte_ready_prev) idx++;
    end
    byte_valid = 1'b0;
  endtask

  // byte_ready as seen by the DUT at the edge just taken.
  logic byte_ready_prev = 1'b0;
  always @(posedge clk) byte_ready_prev <= byte_ready;

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (!load_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (load_done !== 1'b1) begin
      errors++;
      $display("FAIL %s load_done: got %b want 1", name, load_done);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; load_start = 1'b1; rd_req = 1'b1; rd_addr = 4'd3;
    repeat (3) @(negedge clk);
    checks++;
    if ({byte_ready, rd_valid, load_done, busy, mem_load, mem_out_en, rd_ready} !== 7'd0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000000",
               {byte_ready, rd_valid, load_done, busy, mem_load, mem_out_en, rd_ready});
    end
    checks++;
    if ({rd_data, mem_din, mem_address} !== 68'd0) begin
      errors++;
      $display("FAIL reset_data: rd_data=%h mem_din=%h addr=%h want 0", rd_data, mem_din, mem_address);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, byte_ready, rd_ready} !== 3'b110) begin
      errors++;
      $display("FAIL reset_priority: busy/byte_ready/rd_ready got %b want 110",
               {busy, byte_ready, rd_ready});
    end
    reset = 1'b0; load_start = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, rd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_idle: busy/rd_ready got %b want 01", {busy, rd_ready});
    end
  endtask

  task automatic test_load_b2b;
    run_load(0, 0, 64);
    wait_done("b2b");
    checks++;
    if (wr_cnt != 16) begin
      errors++;
      $display("FAIL b2b_count: got %0d writes want 16", wr_cnt);
    end
    for (int i = 0; i < 16 && i < wr_cnt; i++) begin
      checks++;
      if (log_addr[i] !== 4'(i) || log_data[i] !== exp_word(i)) begin
        errors++;
        $display("FAIL b2b_write%0d: got addr %0d data %h want addr %0d data %h",
                 i, log_addr[i], log_data[i], i, exp_word(i));
      end
    end
  endtask

  task automatic test_load_stall;
    viol = 0;
    run_load(1, 0, 64);
    wait_done("stall");
    checks++;
    if (wr_cnt != 16) begin
      errors++;
      $display("FAIL stall_count: got %0d writes want 16", wr_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== exp_word(i)) begin
        errors++;
        $display("FAIL stall_mem%0d: got %h want %h", i, mem[i], exp_word(i));
      end
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL stall_protocol: got %0d violations want 0", viol);
    end
  endtask

  task automatic test_read;
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 4'd5;
    checks++;
    if (rd_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_ready: got %b want 1", rd_ready);
    end
    @(negedge clk);
    rd_req = 1'b0;
    checks++;
    if ({mem_out_en, mem_address, rd_valid, mem_load} !== {1'b1, 4'd5, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL read_cycle: out_en=%b addr=%0d rd_valid=%b load=%b want 1 5 0 0",
               mem_out_en, mem_address, rd_valid, mem_load);
    end
    @(negedge clk);
    checks++;
    if ({rd_valid, rd_ready, mem_out_en} !== 3'b110 || rd_data !== 32'h17161514) begin
      errors++;
      $display("FAIL read_result: valid/ready/out_en=%b data=%h want 110 17161514",
               {rd_valid, rd_ready, mem_out_en}, rd_data);
    end
    rd_req = 1'b1; rd_addr = 4'd15;
    @(negedge clk);
    rd_req = 1'b0;
    checks++;
    if ({rd_valid, mem_out_en, mem_address} !== {1'b0, 1'b1, 4'd15} || rd_data !== 32'h17161514) begin
      errors++;
      $display("FAIL read_b2b_hold: valid=%b out_en=%b addr=%0d data=%h want 0 1 15 17161514",
               rd_valid, mem_out_en, mem_address, rd_data);
    end
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h3F3E3D3C) begin
      errors++;
      $display("FAIL read_addr15: valid=%b data=%h want 1 3f3e3d3c", rd_valid, rd_data);
    end
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 32'h3F3E3D3C) begin
      errors++;
      $display("FAIL read_pulse: valid=%b data=%h want 0 3f3e3d3c", rd_valid, rd_data);
    end
  endtask

  task automatic test_ignored;
    viol = 0;
    run_load(0, 1, 64);
    wait_done("ignored");
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL ignored_rd_ready: got %0d cycles with rd_ready high want 0", viol);
    end
    checks++;
    if (wr_cnt != 16 || log_addr[15] !== 4'd15 || log_data[15] !== 32'h3F3E3D3C) begin
      errors++;
      $display("FAIL ignored_session: writes=%0d last addr=%0d data=%h want 16 15 3f3e3d3c",
               wr_cnt, log_addr[15], log_data[15]);
    end
    @(negedge clk);
    rd_req = 1'b0;
    checks++;
    if (mem_out_en !== 1'b1 || mem_address !== 4'd2) begin
      errors++;
      $display("FAIL ignored_read_accept: out_en=%b addr=%0d want 1 2", mem_out_en, mem_address);
    end
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h0B0A0908) begin
      errors++;
      $display("FAIL ignored_read_data: valid=%b data=%h want 1 0b0a0908", rd_valid, rd_data);
    end
  endtask

  task automatic test_reset_midload;
    run_load(0, 0, 10);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, load_done, byte_ready, mem_load} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_state: busy/done/byte_ready/load got %b want 0000",
               {busy, load_done, byte_ready, mem_load});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (load_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release: done=%b busy=%b want 0 0", load_done, busy);
    end
    run_load(0, 0, 64);
    wait_done("reload");
    for (int i = 0; i < 16; i += 5) begin
      checks++;
      if (mem[i] !== exp_word(i)) begin
        errors++;
        $display("FAIL reload_mem%0d: got %h want %h", i, mem[i], exp_word(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_b2b();
    test_load_stall();
    test_read();
    test_ignored();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
